// File: rtl/pipe_stage_microseq_if.sv
// Pipeline stage 2 bus: opcode handshake, stall/flush, flags, control word, decode-table config, break.
// master drives the stage inputs; slave is the stage itself.
interface pipe_stage_microseq_if #(
    parameter int OPW    = 8,
    parameter int CTRLW  = 16,
    parameter int STEPW  = 2,
    parameter int NFLAGS = 7,
    parameter int CONDW  = 3
);
    logic [OPW-1:0]           PipeIn;
    logic                     PipeInValid;
    logic                     PipeInReady;
    logic [OPW-1:0]           PipeOut;
    logic                     PipeOutValid;
    logic                     Stall;
    logic                     Flush;
    logic [NFLAGS-1:0]        Flags;
    logic [CTRLW-1:0]         CtrlOut;
    logic [STEPW-1:0]         StepOut;
    logic                     CfgWe;
    logic [OPW+STEPW-1:0]     CfgAddr;
    logic [CTRLW+CONDW+1:0]   CfgData;
    logic                     BreakResume;
    logic                     Halted;

    modport master (
        output PipeIn, PipeInValid, Stall, Flush, Flags, CfgWe, CfgAddr, CfgData, BreakResume,
        input  PipeInReady, PipeOut, PipeOutValid, CtrlOut, StepOut, Halted
    );

    modport slave (
        input  PipeIn, PipeInValid, Stall, Flush, Flags, CfgWe, CfgAddr, CfgData, BreakResume,
        output PipeInReady, PipeOut, PipeOutValid, CtrlOut, StepOut, Halted
    );
endinterface

// File: rtl/pipe_stage_microseq.sv
// Micro-sequenced decode stage: table-driven control word per step, 1 instr/cycle when single-step, ready drops while multi-stepping/stalled.
// Optional break/halt support under PIPE_STAGE_MICROSEQ_BREAK_EN.
module pipe_stage_microseq #(
    parameter int OPW       = 8,
    parameter int CTRLW     = 16,
    parameter int STEPW     = 2,
    parameter int NFLAGS    = 7,
    parameter int CONDW     = 3,
    parameter int BREAK_BIT = 15
) (
    input logic                 ClockIn,
    input logic                 Reset,
    pipe_stage_microseq_if.slave pipe
);
    localparam int ENTW  = CTRLW + CONDW + 2;
    localparam int DEPTH = 2 ** (OPW + STEPW);

    logic [ENTW-1:0]  decodeTable [DEPTH];

    logic [OPW-1:0]   opcodeQ;
    logic             validQ;
    logic [STEPW-1:0] stepQ;
    logic [OPW-1:0]   pipeOutQ;
    logic             pipeOutValidQ;

    logic [ENTW-1:0]  entry;
    logic [CTRLW-1:0] entryCtrl;
    logic [CONDW-1:0] entrySel;
    logic             entryInv;
    logic             entryLast;
    logic             flagSel;
    logic             selInRange;
    logic             condPass;
    logic             done;
    logic             haltedQ;
    logic             hold;

    assign entry     = decodeTable[{opcodeQ, stepQ}];
    assign entryCtrl = entry[CTRLW-1:0];
    assign entrySel  = entry[CTRLW+CONDW-1:CTRLW];
    assign entryInv  = entry[CTRLW+CONDW];
    assign entryLast = entry[ENTW-1];

    // CondSel is 1-based; selectors past the flag count never pass.
    always_comb begin
        flagSel    = 1'b0;
        selInRange = 1'b0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (int'(entrySel) == i + 1) begin
                flagSel    = pipe.Flags[i];
                selInRange = 1'b1;
            end
        end
        if (entrySel == '0) condPass = 1'b1;
        else                condPass = selInRange & (flagSel ^ entryInv);
    end

    assign done = validQ & (entryLast | ~condPass | (&stepQ));
    assign hold = pipe.Stall | haltedQ;

    assign pipe.CtrlOut      = (validQ & condPass & ~hold & ~pipe.Flush) ? entryCtrl : '0;
    assign pipe.PipeInReady  = ~pipe.Flush & ~hold & (~validQ | done);
    assign pipe.StepOut      = stepQ;
    assign pipe.PipeOut      = pipeOutQ;
    assign pipe.PipeOutValid = pipeOutValidQ;
    assign pipe.Halted       = haltedQ;

    // Table is not reset; the async arm only blocks writes while Reset is high.
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (!Reset && pipe.CfgWe) begin
            decodeTable[pipe.CfgAddr] <= pipe.CfgData;
        end
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            opcodeQ       <= '0;
            validQ        <= 1'b0;
            stepQ         <= '0;
            pipeOutQ      <= '0;
            pipeOutValidQ <= 1'b0;
        end else if (pipe.Flush) begin
            validQ        <= 1'b0;
            stepQ         <= '0;
            pipeOutValidQ <= 1'b0;
        end else if (!hold) begin
            if (done) begin
                pipeOutQ      <= opcodeQ;
                pipeOutValidQ <= 1'b1;
                stepQ         <= '0;
                validQ        <= pipe.PipeInValid;
                if (pipe.PipeInValid) opcodeQ <= pipe.PipeIn;
            end else if (validQ) begin
                stepQ         <= stepQ + 1'b1;
                pipeOutValidQ <= 1'b0;
            end else begin
                pipeOutValidQ <= 1'b0;
                if (pipe.PipeInValid) begin
                    opcodeQ <= pipe.PipeIn;
                    validQ  <= 1'b1;
                end
            end
        end
    end

`ifdef PIPE_STAGE_MICROSEQ_BREAK_EN
    logic breakHit;

    // The break step advances normally at its edge; only the freeze is added.
    assign breakHit = validQ & condPass & entryCtrl[BREAK_BIT] & ~hold & ~pipe.Flush;

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset)                            haltedQ <= 1'b0;
        else if (pipe.Flush)                  haltedQ <= 1'b0;
        else if (haltedQ && pipe.BreakResume) haltedQ <= 1'b0;
        else if (breakHit)                    haltedQ <= 1'b1;
    end
`else
    localparam int unusedBreakBit = BREAK_BIT;
    logic unusedBreakResume;

    assign haltedQ           = 1'b0;
    assign unusedBreakResume = pipe.BreakResume;
`endif
endmodule

// File: tb/tb_pipe_stage_microseq.sv
// Directed bench for pipe_stage_microseq: hand-computed expectations for stream, multi-step, conditions, stall/flush, reset, table writes, break.
module tb_pipe_stage_microseq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testCount = 0;
    int   failCount = 0;

    pipe_stage_microseq_if #(.OPW(8), .CTRLW(16), .STEPW(2), .NFLAGS(7), .CONDW(3)) bus ();

    pipe_stage_microseq #(.OPW(8), .CTRLW(16), .STEPW(2), .NFLAGS(7), .CONDW(3), .BREAK_BIT(15)) dut (
        .ClockIn(clk),
        .Reset  (rst),
        .pipe   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input logic [7:0] op, input logic [1:0] st, input logic last,
                            input logic inv, input logic [2:0] sel, input logic [15:0] ctrl);
        bus.CfgWe   = 1'b1;
        bus.CfgAddr = {op, st};
        bus.CfgData = {last, inv, sel, ctrl};
        tick();
        bus.CfgWe   = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op);
        bus.PipeIn      = op;
        bus.PipeInValid = 1'b1;
        tick();
        bus.PipeInValid = 1'b0;
        #1;
    endtask

    initial begin
        bus.PipeIn = '0; bus.PipeInValid = 1'b0; bus.Stall = 1'b0; bus.Flush = 1'b0;
        bus.Flags = '0; bus.CfgWe = 1'b0; bus.CfgAddr = '0; bus.CfgData = '0; bus.BreakResume = 1'b0;
        #1;
        checkVal("rst_ctrl", bus.CtrlOut, 0);
        checkVal("rst_pov", bus.PipeOutValid, 0);
        checkVal("rst_step", bus.StepOut, 0);
        checkVal("rst_halt", bus.Halted, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        checkVal("rst_rdy", bus.PipeInReady, 1);

        cfgWrite(8'h10, 2'd0, 1'b1, 1'b0, 3'd0, 16'h0101);
        cfgWrite(8'h11, 2'd0, 1'b1, 1'b0, 3'd0, 16'h0202);
        cfgWrite(8'h20, 2'd0, 1'b0, 1'b0, 3'd0, 16'h0001);
        cfgWrite(8'h20, 2'd1, 1'b0, 1'b0, 3'd0, 16'h0002);
        cfgWrite(8'h20, 2'd2, 1'b1, 1'b0, 3'd0, 16'h0004);
        for (int s = 0; s < 4; s++) cfgWrite(8'h21, 2'(s), 1'b0, 1'b0, 3'd0, 16'h0010 << s);
        cfgWrite(8'h30, 2'd0, 1'b1, 1'b0, 3'd3, 16'h8000);
        cfgWrite(8'h31, 2'd0, 1'b1, 1'b1, 3'd7, 16'h0F0F);
        cfgWrite(8'h40, 2'd0, 1'b0, 1'b0, 3'd0, 16'h8001);
        cfgWrite(8'h40, 2'd1, 1'b1, 1'b0, 3'd0, 16'h0002);
        cfgWrite(8'h50, 2'd0, 1'b1, 1'b0, 3'd0, 16'h00AA);

        // reset mid-instruction with traffic and a table write pending
        issue(8'h20);
        checkVal("pre_rst_ctrl", bus.CtrlOut, 16'h0001);
        rst = 1'b1;
        bus.CfgWe = 1'b1; bus.CfgAddr = {8'h50, 2'd0}; bus.CfgData = {1'b1, 1'b0, 3'd0, 16'h5555};
        bus.PipeIn = 8'h11; bus.PipeInValid = 1'b1;
        #1;
        checkVal("mid_rst_ctrl", bus.CtrlOut, 0);
        checkVal("mid_rst_step", bus.StepOut, 0);
        checkVal("mid_rst_pov", bus.PipeOutValid, 0);
        tick(); tick();
        rst = 1'b0; bus.CfgWe = 1'b0; bus.PipeInValid = 1'b0;
        #1;
        checkVal("post_rst_rdy", bus.PipeInReady, 1);
        checkVal("post_rst_ctrl", bus.CtrlOut, 0);
        tick();
        checkVal("post_rst_noretire", bus.PipeOutValid, 0);

        // back-to-back single-step stream
        bus.PipeIn = 8'h10; bus.PipeInValid = 1'b1;
        #1;
        checkVal("ss_rdy0", bus.PipeInReady, 1);
        tick();
        bus.PipeIn = 8'h11;
        #1;
        checkVal("ss_ctrl0", bus.CtrlOut, 16'h0101);
        checkVal("ss_rdy1", bus.PipeInReady, 1);
        tick();
        bus.PipeInValid = 1'b0;
        #1;
        checkVal("ss_ctrl1", bus.CtrlOut, 16'h0202);
        checkVal("ss_out0", bus.PipeOut, 8'h10);
        checkVal("ss_pov0", bus.PipeOutValid, 1);
        tick();
        checkVal("ss_out1", bus.PipeOut, 8'h11);
        checkVal("ss_pov1", bus.PipeOutValid, 1);
        checkVal("ss_ctrl_idle", bus.CtrlOut, 0);
        bus.Stall = 1'b1;
        tick();
        checkVal("stall_hold_pov", bus.PipeOutValid, 1);
        checkVal("stall_hold_out", bus.PipeOut, 8'h11);
        bus.Stall = 1'b0;
        tick();
        checkVal("ss_pov_drop", bus.PipeOutValid, 0);

        // three-step instruction
        issue(8'h20);
        checkVal("ms_step0", bus.StepOut, 0);
        checkVal("ms_ctrl0", bus.CtrlOut, 16'h0001);
        checkVal("ms_rdy0", bus.PipeInReady, 0);
        tick();
        checkVal("ms_step1", bus.StepOut, 1);
        checkVal("ms_ctrl1", bus.CtrlOut, 16'h0002);
        checkVal("ms_rdy1", bus.PipeInReady, 0);
        tick();
        checkVal("ms_step2", bus.StepOut, 2);
        checkVal("ms_ctrl2", bus.CtrlOut, 16'h0004);
        checkVal("ms_rdy2", bus.PipeInReady, 1);
        tick();
        checkVal("ms_out", bus.PipeOut, 8'h20);
        checkVal("ms_pov", bus.PipeOutValid, 1);
        checkVal("ms_step_rst", bus.StepOut, 0);

        // no Last bit: the final step still ends the instruction
        issue(8'h21);
        for (int s = 0; s < 4; s++) begin
            checkVal("fs_step", bus.StepOut, s);
            checkVal("fs_ctrl", bus.CtrlOut, 32'h10 << s);
            checkVal("fs_rdy", bus.PipeInReady, (s == 3) ? 1 : 0);
            tick();
        end
        checkVal("fs_out", bus.PipeOut, 8'h21);
        checkVal("fs_pov", bus.PipeOutValid, 1);

        // conditional on Flags[2]
        bus.Flags = 7'b0000000;
        issue(8'h30);
        checkVal("cond_fail_ctrl", bus.CtrlOut, 0);
        checkVal("cond_fail_rdy", bus.PipeInReady, 1);
        tick();
        checkVal("cond_fail_out", bus.PipeOut, 8'h30);
        checkVal("cond_fail_pov", bus.PipeOutValid, 1);
        bus.Flags = 7'b0000100;
        issue(8'h30);
        checkVal("cond_pass_ctrl", bus.CtrlOut, 16'h8000);
        tick();
        checkVal("cond_pass_out", bus.PipeOut, 8'h30);
`ifdef PIPE_STAGE_MICROSEQ_BREAK_EN
        checkVal("cond_pass_halt", bus.Halted, 1);
        bus.BreakResume = 1'b1;
        tick();
        bus.BreakResume = 1'b0;
        checkVal("cond_pass_resume", bus.Halted, 0);
`else
        checkVal("cond_pass_nohalt", bus.Halted, 0);
`endif
        bus.Flags = 7'b0000000;

        // inverted condition on the highest flag
        bus.Flags = 7'b1000000;
        issue(8'h31);
        checkVal("inv_set_ctrl", bus.CtrlOut, 0);
        tick();
        bus.Flags = 7'b0000000;
        issue(8'h31);
        checkVal("inv_clr_ctrl", bus.CtrlOut, 16'h0F0F);
        tick();

        // stall at step 1
        issue(8'h20);
        tick();
        bus.Stall = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            checkVal("stall_step", bus.StepOut, 1);
            checkVal("stall_ctrl", bus.CtrlOut, 0);
            checkVal("stall_rdy", bus.PipeInReady, 0);
            tick();
        end
        bus.Stall = 1'b0;
        #1;
        checkVal("unstall_ctrl", bus.CtrlOut, 16'h0002);
        checkVal("unstall_step", bus.StepOut, 1);
        tick();
        checkVal("unstall_ctrl2", bus.CtrlOut, 16'h0004);
        tick();
        checkVal("unstall_out", bus.PipeOut, 8'h20);
        checkVal("unstall_pov", bus.PipeOutValid, 1);

        // flush at step 1, with an incoming opcode that must not be taken
        issue(8'h20);
        tick();
        bus.Flush = 1'b1; bus.PipeIn = 8'h10; bus.PipeInValid = 1'b1;
        #1;
        checkVal("flush_ctrl", bus.CtrlOut, 0);
        checkVal("flush_rdy", bus.PipeInReady, 0);
        tick();
        bus.Flush = 1'b0; bus.PipeInValid = 1'b0;
        #1;
        checkVal("flush_step", bus.StepOut, 0);
        checkVal("flush_idle_ctrl", bus.CtrlOut, 0);
        checkVal("flush_pov", bus.PipeOutValid, 0);
        checkVal("flush_rdy_after", bus.PipeInReady, 1);
        tick();
        checkVal("flush_noretire", bus.PipeOutValid, 0);

        // write during reset ignored; same-cycle lookup sees the old entry
        issue(8'h50);
        bus.CfgWe = 1'b1; bus.CfgAddr = {8'h50, 2'd0}; bus.CfgData = {1'b1, 1'b0, 3'd0, 16'h0BBB};
        #1;
        checkVal("wr_old_ctrl", bus.CtrlOut, 16'h00AA);
        tick();
        bus.CfgWe = 1'b0;
        tick();
        issue(8'h50);
        checkVal("wr_new_ctrl", bus.CtrlOut, 16'h0BBB);
        tick();

        // break bit on step 0 of op 0x40
        issue(8'h40);
        checkVal("brk_ctrl0", bus.CtrlOut, 16'h8001);
        tick();
`ifdef PIPE_STAGE_MICROSEQ_BREAK_EN
        checkVal("brk_halted", bus.Halted, 1);
        checkVal("brk_ctrl_frozen", bus.CtrlOut, 0);
        checkVal("brk_step", bus.StepOut, 1);
        checkVal("brk_rdy", bus.PipeInReady, 0);
        tick();
        checkVal("brk_halted2", bus.Halted, 1);
        checkVal("brk_ctrl_frozen2", bus.CtrlOut, 0);
        bus.BreakResume = 1'b1;
        tick();
        bus.BreakResume = 1'b0;
        #1;
        checkVal("brk_resumed", bus.Halted, 0);
`else
        checkVal("brk_off_halted", bus.Halted, 0);
`endif
        checkVal("brk_step1_ctrl", bus.CtrlOut, 16'h0002);
        checkVal("brk_step1", bus.StepOut, 1);
        tick();
        checkVal("brk_out", bus.PipeOut, 8'h40);
        checkVal("brk_pov", bus.PipeOutValid, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
